// File: rtl/alu_sequencer.sv
// Read/execute/write-back sequencer driving a 16-entry regfile and a 16-bit ALU.
// Optional `ALU_SEQ_ILLEGAL_TRAP_EN: illegal opcodes set sticky err and force out_result to 16'hFFFF.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic [15:0] alu_out,
  output logic [15:0] alu_instruction,
  output logic [3:0]  rf_read_register_1,
  output logic [3:0]  rf_read_register_2,
  output logic [3:0]  rf_write_register,
  output logic        rf_enable_write,
  output logic        out_valid,
  output logic [15:0] out_result,
  input  logic        out_ready,
  output logic        busy,
  output logic        err,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_ir;
  logic [15:0] r_out_result;
  logic        r_out_valid;
  logic        r_we;
  logic        r_busy;
  logic [15:0] r_instr_count;
  logic        w_legal;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= 4'd10);
  endfunction

  assign w_legal = is_legal(r_ir[15:12]);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == S_EXEC && !w_legal) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ir          <= 16'h0000;
      r_out_result  <= 16'h0000;
      r_out_valid   <= 1'b0;
      r_we          <= 1'b0;
      r_busy        <= 1'b0;
      r_instr_count <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ir    <= in_instr;
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
          r_out_result <= w_legal ? alu_out : 16'hFFFF;
`else
          r_out_result <= alu_out;
`endif
          // Illegal opcodes never write back, trap or not.
          r_we    <= w_legal;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_we        <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_instr_count <= r_instr_count + 16'd1;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // in_ready is gated by rst_n so it reads 0 while reset is held.
  assign in_ready           = rst_n && (r_state == S_IDLE);
  assign alu_instruction    = r_ir;
  assign rf_read_register_1 = r_ir[7:4];
  assign rf_read_register_2 = r_ir[3:0];
  assign rf_write_register  = r_ir[11:8];
  assign rf_enable_write    = r_we;
  assign out_valid          = r_out_valid;
  assign out_result         = r_out_result;
  assign busy               = r_busy;
  assign instr_count        = r_instr_count;

endmodule
